pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush scheduler for the five-stage integer pipeline. It drives the load-enable and bubble-insert controls of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB):
- detects load-use hazards,
- squashes wrong-path instructions on taken branches,
- freezes the pipeline around a multi-cycle data-memory handshake with timeout,
- counts stall cycles for performance monitoring.

## Interface
- TIMEOUT, 16: maximum MEM_WAIT cycles without ack before error; legal range ≥1.
- CNT_W, 16: width of stall counter.

- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_rs1, id_rs2  in  `ASIZE`  source register addresses of instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_wen  in  1  EX instruction writes a register.
- ex_mem_to_reg  in  1  EX instruction is a load.
- ex_waddr  in  `ASIZE`  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- mem_req  in  1  MEM instruction accesses data memory.
- mem_ack  in  1  data memory completes access this cycle.
- dmem_req  out  1  request to data memory.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (wen=0, mem_to_reg=0) at next edge; flush overrides enable.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
States: RUN, MEM_WAIT, ERR. Reset state RUN, wait_cnt=0, stall_cnt=0.

While rst high:
- all enables 0;
- all flushes 1;
- dmem_req=0, mem_err=0, stall_cnt=0.

load_use = ex_mem_to_reg & ex_wen & ex_waddr≠0 & ((id_uses_rs1 & id_rs1==ex_waddr) | (id_uses_rs2 & id_rs2==ex_waddr)).

RUN priority (highest first):
1. mem_req & !mem_ack → memory stall:
   - all enables 0 except mem_wb_en=1 with mem_wb_flush=1;
   - if_id_flush=id_ex_flush=0;
   - next MEM_WAIT, wait_cnt←1.
2. ex_branch_taken → all enables 1, if_id_flush=1, id_ex_flush=1.
3. load_use → pc_en=0, if_id_en=0, id_ex_flush=1, remaining enables 1.
4. Otherwise all enables 1, no flush.

MEM_WAIT:
- mem_ack (or mem_req dropped, treated as completion):
  - apply RUN rules 2–4 for this cycle; memory completion permits advance;
  - next RUN.
- Else if wait_cnt==TIMEOUT:
  - next ERR; outputs this cycle as stall.
- Else:
  - stall outputs as rule 1;
  - wait_cnt++.

ERR:
- all enables 0, mem_wb_flush=1, dmem_req=0, mem_err=1;
- exit only by rst.

Common to all states:
- dmem_req = mem_req in RUN and MEM_WAIT.
- stall_cnt increments every cycle with pc_en=0 (including ERR); holds at 2^CNT_W−1.

## Timing
- Enables, flushes and dmem_req are combinational from inputs and state; state, wait_cnt and stall_cnt are registered.
- mem_err is decoded from state, so it asserts the cycle after the timeout decision.
- Zero-wait access: mem_ack in same cycle as mem_req → no stall, no state change.
- N-wait access, N≤TIMEOUT:
  - N stall cycles with ack arriving on the (N+1)th cycle;
  - MEM/WB receives N bubbles, then the real instruction.
- ack on the cycle where wait_cnt==TIMEOUT is accepted: ack wins over timeout.
- Branch or load-use arising during MEM_WAIT takes effect only on the ack cycle; flushes never assert while the front end is frozen.
- Branch and load-use in the same cycle: branch wins; the ID instruction is squashed, not stalled.
- Async rst mid-MEM_WAIT or mid-ERR → RUN immediately; counters cleared.

## Structure
- State encoding (RUN/MEM_WAIT/ERR) and default TIMEOUT belong in define.v alongside `DSIZE`/`ASIZE`.
- Single flat module; hazard compare may be split into a combinational sub-module hazard_detect (outputs load_use). No other sub-modules.

## Test plan
- Load-use: ex load to r5, ID reads rs2=r5 → pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cnt 0→1. Same with ex_waddr=0 → no stall.
- Branch + load-use same cycle → if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- mem_req with ack after 3 cycles:
  - 3 cycles of enables=0, mem_wb_flush=1, dmem_req=1;
  - 4th cycle all enables 1;
  - stall_cnt=3.
- TIMEOUT=4, no ack:
  - ERR entered after 5 cycles of request;
  - mem_err=1, dmem_req=0, enables held 0.
- Ack on the final allowed cycle (TIMEOUT=4, ack on 5th request cycle) → RUN, mem_err=0.
- rst asserted mid-MEM_WAIT (asynchronous) → outputs at reset values immediately; RUN after release; stall_cnt=0. Separately, force 2^16+5 stalled cycles → stall_cnt=0xFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the integer-pipeline stall/flush scheduler.
// Register-file address width, scheduler states and default memory timeout live here.
package pipeline_ctrl_pkg;

  localparam int ASIZE       = 5;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pstate_t;

  // Source operands of the instruction sitting in ID
  typedef struct packed {
    logic [ASIZE-1:0] rs1;
    logic [ASIZE-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
  } id_src_t;

  // Destination of the instruction sitting in EX
  typedef struct packed {
    logic             wen;
    logic             mem_to_reg;
    logic [ASIZE-1:0] waddr;
  } ex_dst_t;

  // Pipeline register controls, PC first
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN    = 8'b11111_000;
  localparam ctl_t CTL_BRANCH = 8'b11111_110;
  localparam ctl_t CTL_LDUSE  = 8'b00111_010;
  // Front end frozen; MEM/WB keeps clocking in bubbles so WB never repeats
  localparam ctl_t CTL_MSTALL = 8'b00001_001;
  localparam ctl_t CTL_ERR    = 8'b00000_001;
  localparam ctl_t CTL_RST    = 8'b00000_111;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: EX load whose destination feeds an ID source operand.
// Purely combinational; r0 is hardwired so it never creates a dependency.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  id_src_t id_src,
  input  ex_dst_t ex_dst,
  output logic    load_use
);

  logic ex_is_load;
  logic hit_rs1;
  logic hit_rs2;

  assign ex_is_load = ex_dst.mem_to_reg & ex_dst.wen & (ex_dst.waddr != '0);
  assign hit_rs1    = id_src.uses_rs1 & (id_src.rs1 == ex_dst.waddr);
  assign hit_rs2    = id_src.uses_rs2 & (id_src.rs2 == ex_dst.waddr);
  assign load_use   = ex_is_load & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the five-stage pipeline: load-use stalls,
// branch squash, data-memory wait freeze with timeout, and a stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs1,
  input  logic [ASIZE-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_wen,
  input  logic             ex_mem_to_reg,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  pstate_t         state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  ctl_t            ctl, ctl_sched;
  logic            load_use;
  logic            dmem_cmb;

  pipeline_ctrl_hazard_detect u_hazard (
    .id_src   ('{rs1: id_rs1, rs2: id_rs2, uses_rs1: id_uses_rs1, uses_rs2: id_uses_rs2}),
    .ex_dst   ('{wen: ex_wen, mem_to_reg: ex_mem_to_reg, waddr: ex_waddr}),
    .load_use (load_use)
  );

  // Front-end hazards; branch beats load-use since the stalled ID op is wrong-path anyway
  always_comb begin
    ctl_sched = CTL_RUN;
    if (ex_branch_taken)
      ctl_sched = CTL_BRANCH;
    else if (load_use)
      ctl_sched = CTL_LDUSE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ctl          = CTL_MSTALL;
    dmem_cmb     = 1'b0;
    case (state)
      RUN: begin
        dmem_cmb = mem_req;
        if (mem_req && !mem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end else begin
          ctl = ctl_sched;
        end
      end
      MEM_WAIT: begin
        dmem_cmb = mem_req;
        // A dropped request is treated as completion; ack also wins over timeout
        if (mem_ack || !mem_req) begin
          ctl          = ctl_sched;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WC_MAX) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ERR: begin
        ctl = CTL_ERR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
    if (rst) begin
      ctl      = CTL_RST;
      dmem_cmb = 1'b0;
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign id_ex_en     = ctl.id_ex_en;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_en    = ctl.mem_wb_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign mem_wb_flush = ctl.mem_wb_flush;
  assign dmem_req     = dmem_cmb;
  assign mem_err      = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (!ctl.pc_en && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected control vectors are queued as each
// cycle's stimulus is driven and popped/compared once the outputs settle.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1, u2, wen, m2r;
    logic [4:0] waddr;
    logic       br, mreq, mack;
  } in_t;

  // ctl bit order: pc,if_id,id_ex,ex_mem,mem_wb | if_id_fl,id_ex_fl,mem_wb_fl | dmem_req | mem_err
  typedef struct packed {
    logic [9:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  localparam logic [9:0] C_NORM  = 10'b11111_000_0_0;
  localparam logic [9:0] C_NORMD = 10'b11111_000_1_0;
  localparam logic [9:0] C_LU    = 10'b00111_010_0_0;
  localparam logic [9:0] C_BR    = 10'b11111_110_0_0;
  localparam logic [9:0] C_BRD   = 10'b11111_110_1_0;
  localparam logic [9:0] C_STALL = 10'b00001_001_1_0;
  localparam logic [9:0] C_ERR   = 10'b00000_001_0_1;
  localparam logic [9:0] C_RST   = 10'b00000_111_0_0;

  localparam in_t S_IDLE    = 22'b0;
  localparam in_t S_MREQ    = 22'b010;
  localparam in_t S_MACK    = 22'b011;
  localparam in_t S_MREQ_BR = 22'b110;
  localparam in_t S_MACK_BR = 22'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_waddr = '0;
  logic        id_uses_rs1 = 0, id_uses_rs2 = 0, ex_wen = 0, ex_mem_to_reg = 0;
  logic        ex_branch_taken = 0, mem_req = 0, mem_ack = 0;
  logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [15:0] stall_cnt;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   failed = 0;

  logic [9:0] obs_ctl;
  assign obs_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_flush, dmem_req, mem_err};

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_wen(ex_wen), .ex_mem_to_reg(ex_mem_to_reg), .ex_waddr(ex_waddr),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  function automatic in_t st(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic wen, input logic m2r,
                             input logic [4:0] wa, input logic br, input logic mreq, input logic mack);
    st = {rs1, rs2, u1, u2, wen, m2r, wa, br, mreq, mack};
  endfunction

  task automatic apply(input in_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    ex_wen = s.wen; ex_mem_to_reg = s.m2r; ex_waddr = s.waddr;
    ex_branch_taken = s.br; mem_req = s.mreq; mem_ack = s.mack;
  endtask

  // Synchronous-looking reset pulse between scenarios; leaves us at a negedge
  task automatic do_reset();
    apply(S_IDLE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply(S_MACK);
    rst = 1'b1;
    @(negedge clk);
    sb.push_back('{C_RST, 16'd0});
    #2;
    e = sb.pop_front(); tests++;
    if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      failed++;
      $display("FAIL reset: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", obs_ctl, stall_cnt, e.ctl, e.cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(S_IDLE);
  endtask

  task automatic test_load_use();
    in_t  stim [6] = '{st(1,5,1,1,1,1,5,0,0,0), S_IDLE, st(0,0,1,1,1,1,0,0,0,0),
                       st(5,7,0,1,1,1,5,0,0,0), st(5,7,1,0,1,0,5,0,0,0), st(5,7,1,0,1,1,5,0,0,0)};
    exp_t want [6] = '{'{C_LU,16'd0}, '{C_NORM,16'd1}, '{C_NORM,16'd1},
                       '{C_NORM,16'd1}, '{C_NORM,16'd1}, '{C_LU,16'd1}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i]); sb.push_back(want[i]); #2;
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL load_use[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    in_t  stim [3] = '{st(3,5,1,1,1,1,5,1,0,0), S_IDLE, st(9,9,1,0,1,0,2,1,0,0)};
    exp_t want [3] = '{'{C_BR,16'd0}, '{C_NORM,16'd0}, '{C_BR,16'd0}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i]); sb.push_back(want[i]); #2;
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL branch[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  // 3-wait access, zero-wait access, branch held off until ack, request withdrawn
  task automatic test_mem_wait();
    in_t  stim [11] = '{S_MREQ, S_MREQ, S_MREQ, S_MACK, S_IDLE, S_MACK,
                        S_MREQ_BR, S_MACK_BR, S_MREQ, S_IDLE, S_IDLE};
    exp_t want [11] = '{'{C_STALL,16'd0}, '{C_STALL,16'd1}, '{C_STALL,16'd2}, '{C_NORMD,16'd3},
                        '{C_NORM,16'd3}, '{C_NORMD,16'd3}, '{C_STALL,16'd3}, '{C_BRD,16'd4},
                        '{C_STALL,16'd4}, '{C_NORM,16'd5}, '{C_NORM,16'd5}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i]); sb.push_back(want[i]); #2;
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL mem_wait[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    in_t  stim [8] = '{S_MREQ, S_MREQ, S_MREQ, S_MREQ, S_MREQ, S_MREQ, S_MACK, S_IDLE};
    exp_t want [8] = '{'{C_STALL,16'd0}, '{C_STALL,16'd1}, '{C_STALL,16'd2}, '{C_STALL,16'd3},
                       '{C_STALL,16'd4}, '{C_ERR,16'd5}, '{C_ERR,16'd6}, '{C_ERR,16'd7}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i]); sb.push_back(want[i]); #2;
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL timeout[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ack_last();
    in_t  stim [6] = '{S_MREQ, S_MREQ, S_MREQ, S_MREQ, S_MACK, S_IDLE};
    exp_t want [6] = '{'{C_STALL,16'd0}, '{C_STALL,16'd1}, '{C_STALL,16'd2}, '{C_STALL,16'd3},
                       '{C_NORMD,16'd4}, '{C_NORM,16'd4}};
    do_reset();
    foreach (stim[i]) begin
      apply(stim[i]); sb.push_back(want[i]); #2;
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL ack_last[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    exp_t want [4] = '{'{C_STALL,16'd0}, '{C_STALL,16'd1}, '{C_RST,16'd0}, '{C_NORM,16'd0}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        apply(S_MREQ); #2;
      end else if (i == 2) begin
        #1 rst = 1'b1; #1;
      end else begin
        rst = 1'b0; apply(S_IDLE); #2;
      end
      sb.push_back(want[i]);
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL async_reset[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  // Park in ERR long enough to wrap a 16-bit counter, then reset out of ERR
  task automatic test_saturation();
    exp_t want [3] = '{'{C_ERR,16'hFFFF}, '{C_RST,16'd0}, '{C_NORM,16'd0}};
    do_reset();
    apply(S_MREQ);
    repeat (65536 + 5 + 6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        #2;
      end else if (i == 1) begin
        #1 rst = 1'b1; #1;
      end else begin
        rst = 1'b0; apply(S_IDLE); #2;
      end
      sb.push_back(want[i]);
      e = sb.pop_front(); tests++;
      if ({obs_ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        failed++;
        $display("FAIL saturation[%0d]: got ctl=%b cnt=%0h, expected ctl=%b cnt=%0h", i, obs_ctl, stall_cnt, e.ctl, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_ack_last();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
